bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/bcd_countdown_timer.sv | 176 +++++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// BCD elapsed/remaining timer with IDLE/RUN/PAUSE/DONE control and a registered display.
// Optional lap capture register enabled by defining LAP_CAPTURE_EN.
module bcd_countdown_timer #(
    parameter int DIGITS = 2,
    parameter int W      = 4 * DIGITS
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Tick,
    input  logic         Start,
    input  logic         Stop,
    input  logic         Clear,
    input  logic         ModeSel,
    input  logic [W-1:0] Limit,
`ifdef LAP_CAPTURE_EN
    input  logic         Lap,
    output logic [W-1:0] LapOut,
`endif
    output logic [W-1:0] Count,
    output logic [W-1:0] Display,
    output logic         Running,
    output logic         Done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_count;
    logic [W-1:0]   w_count_next;
    logic [W-1:0]   r_limit;
    logic [W-1:0]   r_display;
    logic [W-1:0]   w_limit_clamped;
    logic [W-1:0]   w_count_inc;
    logic [W-1:0]   w_remaining;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Carry out of the top digit is simply dropped.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         borrow;
        logic [4:0]   t;
        r      = '0;
        borrow = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
            if (t[4]) begin
                r[4*i +: 4] = t[3:0] + 4'd10;
                borrow      = 1'b1;
            end else begin
                r[4*i +: 4] = t[3:0];
                borrow      = 1'b0;
            end
        end
        return r;
    endfunction

    assign w_limit_clamped = bcd_clamp(Limit);
    assign w_count_inc     = bcd_inc(r_count);
    assign w_remaining     = bcd_sub(r_limit, r_count);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through this block infers a latch.
        w_state_next = r_state;
        w_count_next = r_count;
        if (Clear) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        w_count_next = '0;
                        w_state_next = (w_limit_clamped == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (Stop) begin
                        w_state_next = S_PAUSE;
                    end else if (Tick) begin
                        w_count_next = w_count_inc;
                        if (w_count_inc == r_limit) w_state_next = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (!Stop && Start) w_state_next = S_RUN;
                end
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Running = (r_state == S_RUN);
        Done    = (r_state == S_DONE);
        Count   = r_count;
        Display = r_display;
    end

    // In IDLE the limit tracks the input so the remaining display previews it.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_limit <= '0;
        end else if (r_state == S_IDLE) begin
            r_limit <= w_limit_clamped;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_display <= '0;
        end else begin
            r_display <= ModeSel ? w_remaining : r_count;
        end
    end

`ifdef LAP_CAPTURE_EN
    logic [W-1:0] r_lap;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lap <= '0;
        end else if (Clear) begin
            r_lap <= '0;
        end else if (r_state == S_RUN && Lap) begin
            r_lap <= r_display;
        end
    end

    assign LapOut = r_lap;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer (DIGITS=2): a decimal reference model pushes
// expected outputs as stimulus is applied; they are popped and asserted after each edge.
module tb_bcd_countdown_timer;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         Clock;
    logic         Reset_n;
    logic         Tick;
    logic         Start;
    logic         Stop;
    logic         Clear;
    logic         ModeSel;
    logic [W-1:0] Limit;
    logic [W-1:0] Count;
    logic [W-1:0] Display;
    logic         Running;
    logic         Done;
`ifdef LAP_CAPTURE_EN
    logic         Lap;
    logic [W-1:0] LapOut;
`endif

    bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Tick    (Tick),
        .Start   (Start),
        .Stop    (Stop),
        .Clear   (Clear),
        .ModeSel (ModeSel),
        .Limit   (Limit),
`ifdef LAP_CAPTURE_EN
        .Lap     (Lap),
        .LapOut  (LapOut),
`endif
        .Count   (Count),
        .Display (Display),
        .Running (Running),
        .Done    (Done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        string        tag;
        logic [W-1:0] exp;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_mis = 0;

    // Reference model in plain decimal: 0=IDLE 1=RUN 2=PAUSE 3=DONE.
    int m_state = 0;
    int m_count = 0;
    int m_limit = 0;
    int m_disp  = 0;
    int m_lap   = 0;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [3:0] h;
        logic [3:0] l;
        h = 4'(v / 10);
        l = 4'(v % 10);
        return {h, l};
    endfunction

    function automatic int clamp_dec(input logic [W-1:0] v);
        int h;
        int l;
        h = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        l = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return h * 10 + l;
    endfunction

    task automatic push(input string tag, input logic [W-1:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input logic [W-1:0] obs);
        sb_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: observed %h, nothing expected", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_mis++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        push(tag, exp);
        pop_cmp(obs);
    endtask

    // One clock: model predicts from current inputs, DUT is checked #1 after the edge.
    task automatic step();
        int ns, nc, nl, nd, nlap, lim;
        lim  = clamp_dec(Limit);
        nd   = ModeSel ? (m_limit - m_count) : m_count;
        nl   = (m_state == 0) ? lim : m_limit;
        nlap = m_lap;
`ifdef LAP_CAPTURE_EN
        if (Clear) nlap = 0;
        else if (m_state == 1 && Lap) nlap = m_disp;
`endif
        ns = m_state;
        nc = m_count;
        if (Clear) begin
            ns = 0;
            nc = 0;
        end else begin
            case (m_state)
                0: if (Start) begin
                       nc = 0;
                       ns = (lim == 0) ? 3 : 1;
                   end
                1: if (Stop) ns = 2;
                   else if (Tick) begin
                       nc = (m_count + 1) % 100;
                       if (nc == m_limit) ns = 3;
                   end
                2: if (!Stop && Start) ns = 1;
                default: ns = m_state;
            endcase
        end
        push("count",   to_bcd(nc));
        push("display", to_bcd(nd));
        push("running", {7'b0, ns == 1});
        push("done",    {7'b0, ns == 3});
`ifdef LAP_CAPTURE_EN
        push("lapout",  to_bcd(nlap));
`endif
        @(posedge Clock);
        #1;
        m_state = ns;
        m_count = nc;
        m_limit = nl;
        m_disp  = nd;
        m_lap   = nlap;
        pop_cmp(Count);
        pop_cmp(Display);
        pop_cmp({7'b0, Running});
        pop_cmp({7'b0, Done});
`ifdef LAP_CAPTURE_EN
        pop_cmp(LapOut);
`endif
    endtask

    task automatic ticks(input int n);
        Tick = 1'b1;
        repeat (n) step();
        Tick = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0;
        Tick    = 1'b0;
        Start   = 1'b0;
        Stop    = 1'b0;
        Clear   = 1'b0;
        ModeSel = 1'b0;
        Limit   = 8'h00;
`ifdef LAP_CAPTURE_EN
        Lap     = 1'b0;
`endif
        #2;
        chk("reset_count",   Count,            8'h00);
        chk("reset_display", Display,          8'h00);
        chk("reset_running", {7'b0, Running},  8'h00);
        chk("reset_done",    {7'b0, Done},     8'h00);
        #10;
        Reset_n = 1'b1;

        // Elapsed then remaining display, BCD carry/borrow, terminal count.
        Limit = 8'h29;
        step();
        Start = 1'b1;
        step();
        Start = 1'b0;
        ticks(5);
        step();
        chk("seq1_count",   Count,   8'h05);
        chk("seq1_disp_m0", Display, 8'h05);
        ModeSel = 1'b1;
        step();
        chk("seq1_disp_m1", Display, 8'h24);
        ticks(4);
        ticks(1);
        chk("carry_count", Count, 8'h10);
        step();
        chk("borrow_display", Display, 8'h19);
        ticks(18);
        chk("pre_done_running", {7'b0, Running}, 8'h01);
        ticks(1);
        chk("done_count",   Count,            8'h29);
        chk("done_flag",    {7'b0, Done},     8'h01);
        chk("done_running", {7'b0, Running},  8'h00);
        step();
        chk("done_display", Display, 8'h00);
        ticks(3);
        Start = 1'b1;
        Stop  = 1'b1;
        step();
        Start = 1'b0;
        Stop  = 1'b0;
        chk("done_hold_count", Count, 8'h29);
        Clear = 1'b1;
        step();
        Clear = 1'b0;

        // Pause/resume, tick ignored on the start edge, Clear beats Start.
        ModeSel = 1'b0;
        Start   = 1'b1;
        Tick    = 1'b1;
        step();
        Start   = 1'b0;
        Tick    = 1'b0;
        chk("start_edge_tick", Count, 8'h00);
        ticks(3);
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        ticks(2);
        chk("pause_count", Count, 8'h03);
        Start = 1'b1;
        step();
        Start = 1'b0;
        ticks(1);
        chk("resume_count", Count, 8'h04);
        Clear = 1'b1;
        Start = 1'b1;
        step();
        Clear = 1'b0;
        Start = 1'b0;
        chk("clear_count",   Count,           8'h00);
        chk("clear_running", {7'b0, Running}, 8'h00);

        // Zero limit finishes at once; out-of-range digits clamp to 9.
        Limit = 8'h00;
        step();
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("zero_limit_done", {7'b0, Done}, 8'h01);
        Clear = 1'b1;
        step();
        Clear   = 1'b0;
        Limit   = 8'h3F;
        ModeSel = 1'b1;
        step();
        step();
        chk("clamp_preview", Display, 8'h39);
        Start = 1'b1;
        step();
        Start = 1'b0;

        // Lap capture in elapsed mode at 17.
        ModeSel = 1'b0;
        ticks(17);
        step();
        chk("lap_display", Display, 8'h17);
`ifdef LAP_CAPTURE_EN
        Lap = 1'b1;
        step();
        Lap = 1'b0;
        chk("lap_capture", LapOut, 8'h17);
        ticks(2);
        chk("lap_hold", LapOut, 8'h17);
`else
        ticks(2);
`endif
        Clear = 1'b1;
        step();
        Clear = 1'b0;

        // Asynchronous reset in the middle of a run.
        Start = 1'b1;
        step();
        Start = 1'b0;
        ticks(4);
        Reset_n = 1'b0;
        #2;
        chk("async_count",   Count,           8'h00);
        chk("async_display", Display,         8'h00);
        chk("async_running", {7'b0, Running}, 8'h00);
        chk("async_done",    {7'b0, Done},    8'h00);
`ifdef LAP_CAPTURE_EN
        chk("async_lapout",  LapOut,          8'h00);
`endif
        m_state = 0;
        m_count = 0;
        m_limit = 0;
        m_disp  = 0;
        m_lap   = 0;
        #3;
        Reset_n = 1'b1;

        // Normal run after reset release.
        Limit = 8'h12;
        step();
        Start = 1'b1;
        step();
        Start = 1'b0;
        ticks(12);
        chk("post_reset_done",  {7'b0, Done}, 8'h01);
        chk("post_reset_count", Count,        8'h12);
        Clear = 1'b1;
        step();
        Clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
